skeleton_test: RTL and testbench
================================

Name: skeleton_test

Overview:
- Self-contained demo single-cycle processor for the ECE550 ISA subset (add, sub, and, or, sll, sra, addi).
- Contains a fixed program ROM, a 32x32 register file, an ALU and a clock-enable divider.
- Exposes regfile and memory debug signals so a bench can check register contents from the read ports of "check" instructions.
- No data-memory instructions are implemented.

Parameters:
- PC_WIDTH, 12, instruction address width; PC wraps modulo 2^PC_WIDTH.

Ports:
- clock  in  1  system clock.
- ctrl_reset  in  1  one clock; reset is asynchronous and active-low (ctrl_reset=0 resets).
- imem_clock  out  1  equals clock.
- dmem_clock  out  1  equals ~clock.
- processor_clock  out  1  divided clock, cnt[1].
- regfile_clock  out  1  equals processor_clock.
- data_readRegA  out  32  regfile port A data, for rs.
- data_readRegB  out  32  regfile port B data, for rt.
- q_dmem  out  32  constant 0.
- q_imem  out  32  ROM[pc], combinational.
- ctrl_writeReg  out  5  rd field.
- ctrl_readRegA  out  5  rs field.
- ctrl_readRegB  out  5  rt field.
- data_writeReg  out  32  ALU result.
- ctrl_writeEnable  out  1  1 for opcode 00000 or 00101, else 0.

Behaviour:
- Reset (async, ctrl_reset low):
  - cnt=0, pc=0, all 32 registers 0.
  - processor_clock and regfile_clock low.
  - Remaining outputs follow combinationally from pc=0.
- Divider: 2-bit cnt increments every clock posedge and wraps 3->0. "Step" is the posedge where cnt goes 1->2, i.e. processor_clock rises.
- Step timing: counting the first posedge with ctrl_reset high as n=1, steps occur at n=2,6,10,… After posedge n, pc = floor((n+2)/4).
- On a step:
  - pc <= pc+1.
  - If ctrl_writeEnable and rd!=0, then reg[rd] <= data_writeReg.
- All state is single clock domain; divided clocks are outputs only, never internal clocks.
- Encoding:
  - opcode [31:27], rd [26:22], rs [21:17], rt [16:12], shamt [11:7], ALUop [6:2], imm [16:0].
  - imm is sign-extended to 32 bits.
- R-type (opcode 00000), by ALUop:
  - 00000 add.
  - 00001 sub.
  - 00010 and.
  - 00011 or.
  - 00100 sll rs by shamt.
  - 00101 sra rs by shamt.
  - Other ALUop values give result 0.
- addi (opcode 00101): rs + simm.
- Other opcodes: result 0, ctrl_writeEnable 0.
- Arithmetic wraps in 32 bits. No overflow exception and no $30 write.
- Regfile reads are combinational; $0 always reads 0.
- ROM contents (all other words 0, i.e. no-op add $0,$0,$0):
  - pc 0 and 1: 0.
  - pc 2+2k: compute instruction k.
  - pc 3+2k: check instruction "add $0,$0,$r(k)", where r(k) is the rd of compute k.
- Compute program, k=0..14:
  - k0: addi $1,$0,65535.
  - k1: sll $2,$1,15.
  - k2: addi $3,$2,32767.
  - k3: sub $4,$1,$1.
  - k4: and $5,$1,$4.
  - k5: sra $6,$1,16.
  - k6: addi $7,$0,1.
  - k7: add $8,$7,$7.
  - k8: add $9,$8,$7.
  - k9: sra $10,$9,2.
  - k10: and $11,$8,$7.
  - k11: sll $12,$2,17.
  - k12: add $13,$3,$7.
  - k13: sra $14,$13,31.
  - k14: add $15,$14,$7.
- Expected $1..$15: 65535, 2147450880, 2147483647, 0, 0, 0, 1, 2, 3, 0, 0, 0, -2147483648, -1, 0.
- Reset asserted mid-run: state clears immediately and execution restarts at pc=0 after release.

Decomposition:
- Package skeleton_pkg holds:
  - opcode constants OP_RTYPE and OP_ADDI.
  - ALUop constants.
  - field bit positions.
  - the ROM program as a constant function/array.
- One sub-module, sp_regfile: 32x32, async active-low clear, two combinational read ports, one write port with enable, $0 hardwired to 0.
- ALU, decode and ROM stay inline in skeleton_test.

Test Plan:
- Hold ctrl_reset=0 -> pc=0, q_imem=0, processor_clock=0, q_dmem=0, data_readRegA=data_readRegB=0.
- Release reset at a negedge, wait 5+8(k+1) posedges for k=0..14 -> data_readRegA=0, data_readRegB matches the k-th expected value (65535, 2147450880, …, -1, 0).
- Clock outputs -> imem_clock==clock, dmem_clock==~clock, processor_clock has period 4 clocks with first rise at posedge 2, regfile_clock==processor_clock.
- k12 overflow: 0x7FFFFFFF+1 -> $13=0x80000000, no other register changes.
- Check instructions write rd=$0 with ctrl_writeEnable=1 -> $0 still reads 0.
- Assert ctrl_reset low at pc=9 asynchronously, then release -> pc=0, all registers 0, the sequence repeats with identical values.

Source files
------------

// File: rtl/skeleton_pkg.sv
// skeleton_pkg: ISA constants, field positions and the fixed demo program ROM
package skeleton_pkg;

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_ADDI  = 5'b00101;

    localparam int OPC_LSB   = 27;
    localparam int RD_LSB    = 22;
    localparam int RS_LSB    = 17;
    localparam int RT_LSB    = 12;
    localparam int SHAMT_LSB = 7;
    localparam int ALUOP_LSB = 2;
    localparam int IMM_W     = 17;

    typedef enum logic [4:0] {
        ALU_ADD = 5'd0,
        ALU_SUB = 5'd1,
        ALU_AND = 5'd2,
        ALU_OR  = 5'd3,
        ALU_SLL = 5'd4,
        ALU_SRA = 5'd5
    } alu_op_e;

    function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] shamt,
                                          input alu_op_e op);
        return {OP_RTYPE, rd, rs, rt, shamt, op, 2'b00};
    endfunction

    function automatic logic [31:0] enc_i(input logic [4:0] rd, input logic [4:0] rs,
                                          input logic [IMM_W-1:0] imm);
        return {OP_ADDI, rd, rs, imm};
    endfunction

    // Compute instruction k of the demo program; its destination is always $(k+1).
    function automatic logic [31:0] compute(input logic [3:0] k);
        logic [31:0] w;
        case (k)
            4'd0:    w = enc_i(5'd1, 5'd0, 17'd65535);
            4'd1:    w = enc_r(5'd2, 5'd1, 5'd0, 5'd15, ALU_SLL);
            4'd2:    w = enc_i(5'd3, 5'd2, 17'd32767);
            4'd3:    w = enc_r(5'd4, 5'd1, 5'd1, 5'd0, ALU_SUB);
            4'd4:    w = enc_r(5'd5, 5'd1, 5'd4, 5'd0, ALU_AND);
            4'd5:    w = enc_r(5'd6, 5'd1, 5'd0, 5'd16, ALU_SRA);
            4'd6:    w = enc_i(5'd7, 5'd0, 17'd1);
            4'd7:    w = enc_r(5'd8, 5'd7, 5'd7, 5'd0, ALU_ADD);
            4'd8:    w = enc_r(5'd9, 5'd8, 5'd7, 5'd0, ALU_ADD);
            4'd9:    w = enc_r(5'd10, 5'd9, 5'd0, 5'd2, ALU_SRA);
            4'd10:   w = enc_r(5'd11, 5'd8, 5'd7, 5'd0, ALU_AND);
            4'd11:   w = enc_r(5'd12, 5'd2, 5'd0, 5'd17, ALU_SLL);
            4'd12:   w = enc_r(5'd13, 5'd3, 5'd7, 5'd0, ALU_ADD);
            4'd13:   w = enc_r(5'd14, 5'd13, 5'd0, 5'd31, ALU_SRA);
            4'd14:   w = enc_r(5'd15, 5'd14, 5'd7, 5'd0, ALU_ADD);
            default: w = '0;
        endcase
        return w;
    endfunction

    // Even words from 2 hold compute instructions; each is followed by a check
    // instruction that places the fresh result on read port B.
    function automatic logic [31:0] rom(input logic [31:0] a);
        logic [4:0] k;
        logic [31:0] w;
        k = 5'((a - 32'd2) >> 1);
        if (a < 32'd2 || a > 32'd31)
            w = '0;
        else
            w = a[0] ? enc_r(5'd0, 5'd0, k + 5'd1, 5'd0, ALU_ADD) : compute(k[3:0]);
        return w;
    endfunction

endpackage

// File: rtl/skeleton_test_if.sv
// skeleton_test_if: debug bundle exposing clocks, ROM word, regfile ports and ALU result
interface skeleton_test_if;
    logic        imem_clock;
    logic        dmem_clock;
    logic        processor_clock;
    logic        regfile_clock;
    logic [31:0] data_readRegA;
    logic [31:0] data_readRegB;
    logic [31:0] q_dmem;
    logic [31:0] q_imem;
    logic [4:0]  ctrl_writeReg;
    logic [4:0]  ctrl_readRegA;
    logic [4:0]  ctrl_readRegB;
    logic [31:0] data_writeReg;
    logic        ctrl_writeEnable;

    modport master (
        output imem_clock, dmem_clock, processor_clock, regfile_clock,
        output data_readRegA, data_readRegB, q_dmem, q_imem,
        output ctrl_writeReg, ctrl_readRegA, ctrl_readRegB, data_writeReg, ctrl_writeEnable
    );

    modport slave (
        input imem_clock, dmem_clock, processor_clock, regfile_clock,
        input data_readRegA, data_readRegB, q_dmem, q_imem,
        input ctrl_writeReg, ctrl_readRegA, ctrl_readRegB, data_writeReg, ctrl_writeEnable
    );
endinterface

// File: rtl/sp_regfile.sv
// sp_regfile: 32x32 register file, two combinational reads, one write, $0 hardwired to zero
module sp_regfile (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr_a,
    input  logic [4:0]  raddr_b,
    output logic [31:0] rdata_a,
    output logic [31:0] rdata_b
);
    logic [31:0] regs [32];

    // Clear everything on reset; writes to $0 are dropped so it can never hold data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (we && waddr != 5'd0) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a == 5'd0) ? '0 : regs[raddr_a];
    assign rdata_b = (raddr_b == 5'd0) ? '0 : regs[raddr_b];
endmodule

// File: rtl/skeleton_test.sv
// skeleton_test: single-cycle demo processor running a fixed ROM program on a divided clock enable
module skeleton_test
    import skeleton_pkg::*;
#(
    parameter int PC_WIDTH = 12
) (
    input  logic            clock,
    input  logic            ctrl_reset,
    skeleton_test_if.master dbg
);
    logic [1:0]          cnt;
    logic [PC_WIDTH-1:0] pc;
    logic                step;
    logic [31:0]         instr;
    logic [4:0]          opcode;
    logic [4:0]          rd;
    logic [4:0]          rs;
    logic [4:0]          rt;
    logic [4:0]          shamt;
    logic [4:0]          aluop;
    logic [31:0]         simm;
    logic [31:0]         a;
    logic [31:0]         b;
    logic [31:0]         result;
    logic                we;

    // The processor advances only on the edge where the divided clock rises (cnt 1 -> 2).
    assign step = (cnt == 2'd1);

    // Divider counter and program counter; everything runs on the fast clock.
    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            cnt <= '0;
            pc  <= '0;
        end else begin
            cnt <= cnt + 2'd1;
            if (step) pc <= pc + PC_WIDTH'(1);
        end
    end

    assign instr  = rom(32'(pc));
    assign opcode = instr[OPC_LSB +: 5];
    assign rd     = instr[RD_LSB +: 5];
    assign rs     = instr[RS_LSB +: 5];
    assign rt     = instr[RT_LSB +: 5];
    assign shamt  = instr[SHAMT_LSB +: 5];
    assign aluop  = instr[ALUOP_LSB +: 5];
    assign simm   = {{(32-IMM_W){instr[IMM_W-1]}}, instr[IMM_W-1:0]};
    assign we     = (opcode == OP_RTYPE) || (opcode == OP_ADDI);

    // ALU: addi or R-type by ALUop; anything unrecognised yields zero.
    always_comb begin
        result = '0;
        if (opcode == OP_ADDI) begin
            result = a + simm;
        end else if (opcode == OP_RTYPE) begin
            case (aluop)
                ALU_ADD: result = a + b;
                ALU_SUB: result = a - b;
                ALU_AND: result = a & b;
                ALU_OR:  result = a | b;
                ALU_SLL: result = a << shamt;
                ALU_SRA: result = 32'($signed(a) >>> shamt);
                default: result = '0;
            endcase
        end
    end

    sp_regfile u_rf (
        .clk     (clock),
        .rst_n   (ctrl_reset),
        .we      (step & we),
        .waddr   (rd),
        .wdata   (result),
        .raddr_a (rs),
        .raddr_b (rt),
        .rdata_a (a),
        .rdata_b (b)
    );

    assign dbg.imem_clock       = clock;
    assign dbg.dmem_clock       = ~clock;
    assign dbg.processor_clock  = cnt[1];
    assign dbg.regfile_clock    = cnt[1];
    assign dbg.data_readRegA    = a;
    assign dbg.data_readRegB    = b;
    assign dbg.q_dmem           = '0;
    assign dbg.q_imem           = instr;
    assign dbg.ctrl_writeReg    = rd;
    assign dbg.ctrl_readRegA    = rs;
    assign dbg.ctrl_readRegB    = rt;
    assign dbg.data_writeReg    = result;
    assign dbg.ctrl_writeEnable = we;
endmodule

// File: tb/tb_skeleton_test.sv
// tb_skeleton_test: scenario tasks checked against an instruction-level model of the demo program
module tb_skeleton_test;
    logic clock = 1'b0;
    logic ctrl_reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   n = 0;

    skeleton_test_if dbg();

    skeleton_test #(.PC_WIDTH(12)) dut (
        .clock      (clock),
        .ctrl_reset (ctrl_reset),
        .dbg        (dbg)
    );

    always #5 clock = ~clock;

    // Program as a table: op 0 add,1 sub,2 and,3 or,4 sll,5 sra,6 addi
    int k_op  [15] = '{6, 4, 6, 1, 2, 5, 6, 0, 0, 5, 2, 4, 0, 5, 0};
    int k_rd  [15] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
    int k_rs  [15] = '{0, 1, 2, 1, 1, 1, 0, 7, 8, 9, 8, 2, 3, 13, 14};
    int k_rt  [15] = '{0, 0, 0, 1, 4, 0, 0, 7, 7, 0, 7, 0, 7, 0, 7};
    int k_sh  [15] = '{0, 15, 0, 0, 0, 16, 0, 0, 0, 2, 0, 17, 0, 31, 0};
    int k_imm [15] = '{65535, 0, 32767, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    logic [31:0] exp_vals [15] = '{32'd65535, 32'd2147450880, 32'h7FFFFFFF, 32'd0, 32'd0,
                                   32'd0, 32'd1, 32'd2, 32'd3, 32'd0, 32'd0, 32'd0,
                                   32'h80000000, 32'hFFFFFFFF, 32'd0};
    logic [31:0] mregs [32];

    function automatic logic [31:0] word(input int pc);
        int k;
        if (pc < 2 || pc > 31) return '0;
        k = (pc - 2) / 2;
        if (pc % 2 == 1) return {15'd0, 5'(k + 1), 12'd0};
        if (k_op[k] == 6) return {5'b00101, 5'(k_rd[k]), 5'(k_rs[k]), 17'(k_imm[k])};
        return {5'd0, 5'(k_rd[k]), 5'(k_rs[k]), 5'(k_rt[k]), 5'(k_sh[k]), 5'(k_op[k]), 2'd0};
    endfunction

    // Register state after the first `steps` instructions have executed.
    task automatic run_model(input int steps);
        logic [31:0] a, b, r;
        int k;
        foreach (mregs[i]) mregs[i] = '0;
        for (int p = 2; p < steps && p <= 31; p += 2) begin
            k = (p - 2) / 2;
            a = mregs[k_rs[k]];
            b = mregs[k_rt[k]];
            case (k_op[k])
                0: r = a + b;
                1: r = a - b;
                2: r = a & b;
                3: r = a | b;
                4: r = a << k_sh[k];
                5: r = $unsigned($signed(a) >>> k_sh[k]);
                default: r = a + 32'(k_imm[k]);
            endcase
            mregs[k_rd[k]] = r;
        end
    endtask

    task automatic start();
        ctrl_reset = 1'b0;
        @(negedge clock);
        ctrl_reset = 1'b1;
        n = 0;
    endtask

    task automatic adv(input int m);
        repeat (m) @(posedge clock);
        n += m;
        @(negedge clock);
    endtask

    task automatic test_reset();
        ctrl_reset = 1'b1;
        #3 ctrl_reset = 1'b0;
        #1;
        checks++; if (dut.pc !== 12'd0) begin failures++; $display("FAIL reset_pc got=%0d exp=0", dut.pc); end
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++; if (dut.pc !== 12'd0) begin failures++; $display("FAIL reset_pc_hold got=%0d exp=0", dut.pc); end
        checks++; if (dbg.q_imem !== 32'd0) begin failures++; $display("FAIL reset_qimem got=%h exp=0", dbg.q_imem); end
        checks++; if (dbg.processor_clock !== 1'b0 || dbg.regfile_clock !== 1'b0) begin failures++; $display("FAIL reset_pclk got=%b%b exp=00", dbg.processor_clock, dbg.regfile_clock); end
        checks++; if (dbg.q_dmem !== 32'd0) begin failures++; $display("FAIL reset_qdmem got=%h exp=0", dbg.q_dmem); end
        checks++; if (dbg.data_readRegA !== 32'd0 || dbg.data_readRegB !== 32'd0) begin failures++; $display("FAIL reset_reads got=%h/%h exp=0/0", dbg.data_readRegA, dbg.data_readRegB); end
        checks++; if (dbg.ctrl_writeEnable !== 1'b1) begin failures++; $display("FAIL reset_we got=%b exp=1", dbg.ctrl_writeEnable); end
    endtask

    task automatic run_sequence(input string tag);
        for (int k = 0; k < 15; k++) begin
            adv(13 + 8 * k - n);
            run_model(3 + 2 * k);
            checks++; if (dbg.data_readRegA !== 32'd0) begin failures++; $display("FAIL %s_readA k=%0d got=%h exp=0", tag, k, dbg.data_readRegA); end
            checks++; if (dbg.data_readRegB !== exp_vals[k]) begin failures++; $display("FAIL %s_readB k=%0d got=%h exp=%h", tag, k, dbg.data_readRegB, exp_vals[k]); end
            checks++; if (dbg.data_writeReg !== exp_vals[k]) begin failures++; $display("FAIL %s_wdata k=%0d got=%h exp=%h", tag, k, dbg.data_writeReg, exp_vals[k]); end
            checks++; if (dbg.ctrl_writeEnable !== 1'b1 || dbg.ctrl_writeReg !== 5'd0) begin failures++; $display("FAIL %s_chk_dst k=%0d got=%b/%0d exp=1/0", tag, k, dbg.ctrl_writeEnable, dbg.ctrl_writeReg); end
            for (int i = 0; i < 32; i++) begin
                checks++; if (dut.u_rf.regs[i] !== mregs[i]) begin failures++; $display("FAIL %s_reg k=%0d r%0d got=%h exp=%h", tag, k, i, dut.u_rf.regs[i], mregs[i]); end
            end
        end
    endtask

    task automatic test_program();
        start();
        run_sequence("prog");
    endtask

    task automatic test_clocks();
        start();
        for (int i = 1; i <= 12; i++) begin
            @(posedge clock);
            n++;
            #1;
            checks++; if (dbg.imem_clock !== 1'b1 || dbg.dmem_clock !== 1'b0) begin failures++; $display("FAIL clk_hi n=%0d got=%b%b exp=10", n, dbg.imem_clock, dbg.dmem_clock); end
            checks++; if (dbg.processor_clock !== ((n % 4) >= 2)) begin failures++; $display("FAIL pclk n=%0d got=%b exp=%b", n, dbg.processor_clock, (n % 4) >= 2); end
            checks++; if (dbg.regfile_clock !== ((n % 4) >= 2)) begin failures++; $display("FAIL rclk n=%0d got=%b exp=%b", n, dbg.regfile_clock, (n % 4) >= 2); end
            @(negedge clock);
            #1;
            checks++; if (dbg.imem_clock !== 1'b0 || dbg.dmem_clock !== 1'b1) begin failures++; $display("FAIL clk_lo n=%0d got=%b%b exp=01", n, dbg.imem_clock, dbg.dmem_clock); end
        end
    endtask

    task automatic test_random();
        int m, steps;
        logic [31:0] w;
        for (int it = 0; it < 10; it++) begin
            start();
            m = $urandom_range(150, 1);
            adv(m);
            steps = (m + 2) / 4;
            run_model(steps);
            w = word(steps);
            checks++; if (dut.pc !== 12'(steps)) begin failures++; $display("FAIL rnd_pc n=%0d got=%0d exp=%0d", m, dut.pc, steps); end
            checks++; if (dbg.q_imem !== w) begin failures++; $display("FAIL rnd_qimem n=%0d got=%h exp=%h", m, dbg.q_imem, w); end
            checks++; if (dbg.ctrl_readRegA !== w[21:17] || dbg.data_readRegA !== mregs[w[21:17]]) begin failures++; $display("FAIL rnd_readA n=%0d got=%0d/%h exp=%0d/%h", m, dbg.ctrl_readRegA, dbg.data_readRegA, w[21:17], mregs[w[21:17]]); end
            checks++; if (dbg.ctrl_readRegB !== w[16:12] || dbg.data_readRegB !== mregs[w[16:12]]) begin failures++; $display("FAIL rnd_readB n=%0d got=%0d/%h exp=%0d/%h", m, dbg.ctrl_readRegB, dbg.data_readRegB, w[16:12], mregs[w[16:12]]); end
            for (int i = 0; i < 16; i++) begin
                checks++; if (dut.u_rf.regs[i] !== mregs[i]) begin failures++; $display("FAIL rnd_reg n=%0d r%0d got=%h exp=%h", m, i, dut.u_rf.regs[i], mregs[i]); end
            end
        end
    endtask

    task automatic test_mid_reset();
        int bad;
        start();
        adv(34);
        checks++; if (dut.pc !== 12'd9) begin failures++; $display("FAIL mid_pc_before got=%0d exp=9", dut.pc); end
        #2 ctrl_reset = 1'b0;
        #1;
        checks++; if (dut.pc !== 12'd0) begin failures++; $display("FAIL mid_pc_async got=%0d exp=0", dut.pc); end
        checks++; if (dbg.processor_clock !== 1'b0) begin failures++; $display("FAIL mid_pclk_async got=%b exp=0", dbg.processor_clock); end
        bad = 0;
        for (int i = 0; i < 32; i++) if (dut.u_rf.regs[i] !== 32'd0) bad++;
        checks++; if (bad != 0) begin failures++; $display("FAIL mid_regs_clear got=%0d_nonzero exp=0", bad); end
        @(negedge clock);
        ctrl_reset = 1'b1;
        n = 0;
        run_sequence("rerun");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_clocks();
        test_program();
        test_random();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
